// File: rtl/seg_mux_signed_pkg.sv
// seg_pkg: shared glyph constants, BCD-to-segment mapping and converter FSM states
package seg_pkg;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    typedef enum logic [0:0] {IDLE, CONV} state_t;
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/seg_mux_signed_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble, one shift/add-3 step per cycle with sticky overflow
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int W  = 8,
    parameter int ND = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W-1:0]    bin,
    output logic            busy,
    output logic            done,
    output logic [4*ND-1:0] bcd,
    output logic            ovf
);
    localparam int CW = $clog2(W + 1);
    state_t state;
    logic [W-1:0] mag;
    logic [CW-1:0] cnt;
    logic [4*ND-1:0] adj;
    always_comb begin
        adj = bcd;
        for (int i = 0; i < ND; i++)
            adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
    end
    assign busy = state == CONV;
    assign done = busy && cnt == CW'(W);
    // a carry out of the top nibble means the value needs more digits than we hold
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mag   <= '0;
            cnt   <= '0;
            bcd   <= '0;
            ovf   <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                state <= CONV;
                mag   <= bin;
                cnt   <= '0;
                bcd   <= '0;
                ovf   <= 1'b0;
            end
        end else if (done) begin
            state <= IDLE;
        end else begin
            {bcd, mag} <= {adj[4*ND-2:0], mag, 1'b0};
            ovf        <= ovf | adj[4*ND-1];
            cnt        <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/seg_mux_signed.sv
// seg_mux_signed: multiplexed common-anode display of a signed value with sign digit and overflow dashes
module seg_mux_signed
    import seg_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int W      = 8,
    parameter int CNTMAX = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    value,
    input  logic            load,
    input  logic [NDIG-1:0] dp,
    output logic            busy,
    output logic [6:0]      seg,
    output logic            dp_n,
    output logic [NDIG-1:0] an
);
    localparam int ND = NDIG - 1;
    localparam int CW = CNTMAX > 1 ? $clog2(CNTMAX) : 1;
    localparam int IW = $clog2(NDIG);
    logic sign, start, done, ovf, nz;
    logic [W-1:0] mag_in;
    logic [4*ND-1:0] bcd;
    logic [6:0] disp [NDIG];
    logic [6:0] nxt_disp [NDIG];
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx, nidx;
    assign start  = load && !busy;
    assign mag_in = value[W-1] ? -value : value;
    assign nidx   = idx == IW'(NDIG - 1) ? '0 : idx + 1'b1;
    bin2bcd_seq #(.W(W), .ND(ND)) u_conv (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .bin  (mag_in),
        .busy (busy),
        .done (done),
        .bcd  (bcd),
        .ovf  (ovf)
    );
    // scan from the top digit down; once a non-zero digit is seen, all lower digits are shown
    always_comb begin
        nz           = 1'b0;
        nxt_disp[ND] = ovf || sign ? SEG_DASH : SEG_BLANK;
        for (int i = ND - 1; i >= 0; i--) begin
            nz          = nz | (bcd[4*i+:4] != 4'd0) | (i == 0);
            nxt_disp[i] = ovf ? SEG_DASH : nz ? bcd_to_seg(bcd[4*i+:4]) : SEG_BLANK;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sign <= 1'b0;
            cnt  <= '0;
            idx  <= '0;
            an   <= ~NDIG'(1);
            seg  <= SEG_BLANK;
            dp_n <= 1'b1;
            for (int i = 0; i < NDIG; i++) disp[i] <= SEG_BLANK;
        end else begin
            if (start) sign <= value[W-1];
            if (done) disp <= nxt_disp;
            if (cnt == CW'(CNTMAX - 1)) begin
                cnt  <= '0;
                idx  <= nidx;
                an   <= ~(NDIG'(1) << nidx);
                seg  <= disp[nidx];
                dp_n <= ~dp[nidx];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_mux_signed.sv
// tb_seg_mux_signed: directed checks of conversion, blanking, overflow, scan, dp and reset behaviour
module tb_seg_mux_signed;
    localparam logic [6:0] B = 7'b1111111;
    localparam logic [6:0] D = 7'b0111111;
    logic clk = 1'b0;
    logic rst, load;
    logic [7:0] value;
    logic [3:0] dp;
    logic [2:0] dp3;
    logic busy4, busy3, dp_n4, dp_n3;
    logic [6:0] seg4, seg3;
    logic [3:0] an4;
    logic [2:0] an3;
    logic [6:0] rd4 [4];
    logic [6:0] rd3 [3];
    int total = 0;
    int bad = 0;

    seg_mux_signed #(.NDIG(4), .W(8), .CNTMAX(4)) dut4 (
        .clk(clk), .rst(rst), .value(value), .load(load), .dp(dp),
        .busy(busy4), .seg(seg4), .dp_n(dp_n4), .an(an4)
    );
    seg_mux_signed #(.NDIG(3), .W(8), .CNTMAX(4)) dut3 (
        .clk(clk), .rst(rst), .value(value), .load(load), .dp(dp3),
        .busy(busy3), .seg(seg3), .dp_n(dp_n3), .an(an3)
    );

    always #5 clk = ~clk;

    task automatic read_scan();
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) rd4[i] = 'x;
        for (int i = 0; i < 3; i++) rd3[i] = 'x;
        repeat (20) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (an4 == ~(4'b0001 << i)) rd4[i] = seg4;
            for (int i = 0; i < 3; i++) if (an3 == ~(3'b001 << i)) rd3[i] = seg3;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy4 || busy3) && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy4 || busy3) begin
            bad++;
            $display("FAIL %s busy_timeout busy4=%b busy3=%b want 0", name, busy4, busy3);
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        rst = 1'b1; load = 1'b0; value = '0; dp = '0; dp3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total += 5;
        if (seg4 !== B) begin bad++; $display("FAIL reset_seg got=%b want=%b", seg4, B); end
        if (an4 !== 4'b1110) begin bad++; $display("FAIL reset_an got=%b want=1110", an4); end
        if (busy4 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy4); end
        if (dp_n4 !== 1'b1) begin bad++; $display("FAIL reset_dp_n got=%b want=1", dp_n4); end
        if (an3 !== 3'b110) begin bad++; $display("FAIL reset_an3 got=%b want=110", an3); end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_an = ~(4'b0001 << ((k / 4) % 4));
            total++;
            if (an4 !== exp_an) begin bad++; $display("FAIL scan_step k=%0d an got=%b want=%b", k, an4, exp_an); end
        end
    endtask

    task automatic test_busy_123();
        logic [27:0] e4;
        @(negedge clk);
        value = 8'd123;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        total++;
        if (busy4 !== 1'b1) begin bad++; $display("FAIL busy_after_T0 got=%b want=1", busy4); end
        repeat (8) @(negedge clk);
        total++;
        if (busy4 !== 1'b1) begin bad++; $display("FAIL busy_after_T8 got=%b want=1", busy4); end
        @(negedge clk);
        total++;
        if (busy4 !== 1'b0) begin bad++; $display("FAIL busy_after_T9 got=%b want=0", busy4); end
        read_scan();
        e4 = {B, 7'b1111001, 7'b0100100, 7'b0110000};
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd4[i] !== e4[7*i+:7]) begin bad++; $display("FAIL v123 d%0d got=%b want=%b", i, rd4[i], e4[7*i+:7]); end
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rd3[i] !== D) begin bad++; $display("FAIL v123_ndig3 d%0d got=%b want=%b", i, rd3[i], D); end
        end
    endtask

    task automatic test_value(input string name, input logic [7:0] v, input logic [27:0] e4, input logic [20:0] e3);
        do_load(v);
        wait_idle(name);
        read_scan();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd4[i] !== e4[7*i+:7]) begin bad++; $display("FAIL %s d%0d got=%b want=%b", name, i, rd4[i], e4[7*i+:7]); end
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rd3[i] !== e3[7*i+:7]) begin bad++; $display("FAIL %s_ndig3 d%0d got=%b want=%b", name, i, rd3[i], e3[7*i+:7]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [27:0] e4;
        logic [20:0] e3;
        do_load(8'd42);
        repeat (2) @(negedge clk);
        value = 8'd7;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        wait_idle("ignore_load");
        read_scan();
        e4 = {B, B, 7'b0011001, 7'b0100100};
        e3 = {B, 7'b0011001, 7'b0100100};
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd4[i] !== e4[7*i+:7]) begin bad++; $display("FAIL ignore_load d%0d got=%b want=%b", i, rd4[i], e4[7*i+:7]); end
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rd3[i] !== e3[7*i+:7]) begin bad++; $display("FAIL ignore_load_ndig3 d%0d got=%b want=%b", i, rd3[i], e3[7*i+:7]); end
        end
    endtask

    task automatic test_rst_mid();
        do_load(8'd77);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total += 3;
        if (busy4 !== 1'b0 || busy3 !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b%b want=00", busy4, busy3); end
        if (an4 !== 4'b1110) begin bad++; $display("FAIL rst_mid_an got=%b want=1110", an4); end
        if (seg4 !== B) begin bad++; $display("FAIL rst_mid_seg got=%b want=%b", seg4, B); end
        rst = 1'b0;
        repeat (12) @(negedge clk);
        total++;
        if (busy4 !== 1'b0) begin bad++; $display("FAIL rst_mid_busy_later got=%b want=0", busy4); end
        read_scan();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd4[i] !== B) begin bad++; $display("FAIL rst_mid d%0d got=%b want=%b", i, rd4[i], B); end
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rd3[i] !== B) begin bad++; $display("FAIL rst_mid_ndig3 d%0d got=%b want=%b", i, rd3[i], B); end
        end
    endtask

    task automatic test_dp();
        dp  = 4'b0010;
        dp3 = 3'b010;
        repeat (16) @(negedge clk);
        repeat (16) begin
            @(negedge clk);
            total += 2;
            if (dp_n4 !== (an4 != 4'b1101)) begin bad++; $display("FAIL dp an=%b dp_n got=%b want=%b", an4, dp_n4, an4 != 4'b1101); end
            if (dp_n3 !== (an3 != 3'b101)) begin bad++; $display("FAIL dp_ndig3 an=%b dp_n got=%b want=%b", an3, dp_n3, an3 != 3'b101); end
        end
        dp  = '0;
        dp3 = '0;
    endtask

    initial begin
        test_reset();
        test_busy_123();
        test_value("neg128", 8'h80, {D, 7'b1111001, 7'b0100100, 7'b0000000}, {D, D, D});
        test_value("five", 8'd5, {B, B, B, 7'b0010010}, {B, B, 7'b0010010});
        test_value("zero", 8'd0, {B, B, B, 7'b1000000}, {B, B, 7'b1000000});
        test_value("hundred", 8'd100, {B, 7'b1111001, 7'b1000000, 7'b1000000}, {D, D, D});
        test_value("ninety9", 8'd99, {B, B, 7'b0010000, 7'b0010000}, {B, 7'b0010000, 7'b0010000});
        test_value("neg7", 8'hF9, {D, B, B, 7'b1111000}, {D, B, 7'b1111000});
        test_back_to_back();
        test_rst_mid();
        test_dp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
